divisor_secuencial: RTL

Sequential signed fixed-point divider: the inverse-direction counterpart to the constant-gain multiply/truncate stages. It computes q = (num << FRAC) / den in the same Q format used across the datapath. Estimator stages use it to recover a signal from a gain-scaled value, or to apply a runtime gain reciprocal, without a combinational divider. Restoring algorithm, one quotient bit per clock, start/busy/done handshake, fixed latency.

---
 rtl/divisor_secuencial.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/divisor_secuencial.sv
// Sequential signed Q-format divider: q = (num << FRAC) / den.
// Restoring algorithm, one quotient bit per clock, fixed latency of
// N+FRAC+1 edges from the accepting start edge to the done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; q/ovf/dz hold the last result
// RUN   | one restoring step per edge, N+FRAC steps in total
// FIN   | saturate/sign the magnitude, update q/ovf/dz, pulse done
module divisor_secuencial #(
    parameter int N    = 18,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] num,
    input  logic [N-1:0] den,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         dz
);

    localparam int W  = N + FRAC;
    localparam int CW = $clog2(W + 1);

    localparam logic [W-1:0] POS_LIMIT = W'(2 ** (N - 1) - 1);
    localparam logic [W-1:0] NEG_LIMIT = W'(2 ** (N - 1));
    localparam logic [N-1:0] Q_MAX     = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0] Q_MIN     = {1'b1, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        state;
    logic [W-1:0]  dividend;
    logic [W-1:0]  quo;
    logic [N-1:0]  rem;
    logic [N-1:0]  den_abs;
    logic [CW-1:0] count;
    logic          sign;
    logic          num_neg;
    logic          dz_int;

    // Operand magnitudes; negating -2^(N-1) in N bits yields 2^(N-1) as unsigned.
    logic [N-1:0] num_mag;
    logic [N-1:0] den_mag;
    assign num_mag = num[N-1] ? (-num) : num;
    assign den_mag = den[N-1] ? (-den) : den;

    // One restoring step: the remainder is always below |den|, so the
    // difference fits in N bits and only the compare needs the extra bit.
    logic [N:0]   rem_shift;
    logic [N-1:0] rem_diff;
    logic         take;
    assign rem_shift = {rem, dividend[W-1]};
    assign take      = (rem_shift >= {1'b0, den_abs});
    assign rem_diff  = rem_shift[N-1:0] - den_abs;

    // Result range checks on the unsigned quotient magnitude.
    logic pos_ovf;
    logic neg_ovf;
    assign pos_ovf = !sign && (quo > POS_LIMIT);
    assign neg_ovf = sign && (quo > NEG_LIMIT);

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dividend <= '0;
            quo      <= '0;
            rem      <= '0;
            den_abs  <= '0;
            count    <= '0;
            sign     <= 1'b0;
            num_neg  <= 1'b0;
            dz_int   <= 1'b0;
            q        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign     <= num[N-1] ^ den[N-1];
                        num_neg  <= num[N-1];
                        dz_int   <= (den == '0);
                        den_abs  <= den_mag;
                        dividend <= {num_mag, {FRAC{1'b0}}};
                        quo      <= '0;
                        rem      <= '0;
                        count    <= CW'(W);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rem      <= take ? rem_diff : rem_shift[N-1:0];
                    quo      <= {quo[W-2:0], take};
                    dividend <= {dividend[W-2:0], 1'b0};
                    count    <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // Divide-by-zero saturates toward the numerator's sign.
                    if (dz_int) begin
                        q   <= num_neg ? Q_MIN : Q_MAX;
                        dz  <= 1'b1;
                        ovf <= 1'b0;
                    end else if (pos_ovf) begin
                        q   <= Q_MAX;
                        dz  <= 1'b0;
                        ovf <= 1'b1;
                    end else if (neg_ovf) begin
                        q   <= Q_MIN;
                        dz  <= 1'b0;
                        ovf <= 1'b1;
                    end else begin
                        q   <= sign ? (-quo[N-1:0]) : quo[N-1:0];
                        dz  <= 1'b0;
                        ovf <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
